// File: rtl/vin_pixel_packer_if.sv
// Pixel-stream bundle between the DVI receiver side and the luma packer.
// The master drives RGB/syncs and err_clr; the slave returns packed luma, syncs and measurements.
interface vin_pixel_packer_if #(
  parameter int PPC     = 2,
  parameter int OUT_BPC = 8,
  parameter int CNT_W   = 12
);
  logic                     de;
  logic                     hsync;
  logic                     vsync;
  logic [7:0]               red;
  logic [7:0]               green;
  logic [7:0]               blue;
  logic                     err_clr;
  logic                     v_pclk;
  logic [PPC*OUT_BPC-1:0]   v_pixel;
  logic                     v_de;
  logic                     v_hsync;
  logic                     v_vsync;
  logic                     align_err;
  logic [CNT_W-1:0]         h_active;
  logic [CNT_W-1:0]         v_active;
  logic                     meas_valid;

  modport master (
    output de, hsync, vsync, red, green, blue, err_clr,
    input  v_pclk, v_pixel, v_de, v_hsync, v_vsync, align_err, h_active, v_active, meas_valid
  );

  modport slave (
    input  de, hsync, vsync, red, green, blue, err_clr,
    output v_pclk, v_pixel, v_de, v_hsync, v_vsync, align_err, h_active, v_active, meas_valid
  );
endinterface

// File: rtl/vin_pixel_packer.sv
// RGB888 -> luma packer (PPC pixels per beat) with skip-frame gating, line realignment and size measurement.
// Strobe one cycle after the last pixel of a group; no backpressure, the stream runs at pixel rate.
module vin_pixel_packer #(
  parameter int PPC         = 2,
  parameter int OUT_BPC     = 8,
  parameter int SKIP_FRAMES = 3,
  parameter int CNT_W       = 12
) (
  input  logic              pclk,
  input  logic              rst_out,
  vin_pixel_packer_if.slave bus
);
  localparam int PW    = (PPC > 1) ? $clog2(PPC) : 1;
  localparam int PIX_W = PPC * OUT_BPC;
  localparam logic [PW-1:0]    LAST      = PW'(PPC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [3:0]       SKIP_INIT = 4'(SKIP_FRAMES);

  function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    logic [15:0] s;
    s = 16'd77 * {8'd0, r} + 16'd150 * {8'd0, g} + 16'd29 * {8'd0, b};
    return 8'(s >> 8);
  endfunction

  logic [7:0]         y8;
  logic [OUT_BPC-1:0] y_now;
  logic               de_rise, de_fall, vs_rise, skipping, emit;
  logic [PW-1:0]      wr_slot;
  logic [CNT_W-1:0]   vcnt_inc;

  logic [PW-1:0]      phase_q, phase_d;
  logic [OUT_BPC-1:0] slot_q [PPC];
  logic [OUT_BPC-1:0] slot_d [PPC];
  logic               last_de_q, last_de_d;
  logic               last_vs_q, last_vs_d;
  logic [3:0]         skip_q, skip_d;
  logic [CNT_W-1:0]   hcnt_q, hcnt_d;
  logic [CNT_W-1:0]   vcnt_q, vcnt_d;
  logic               v_pclk_q, v_pclk_d;
  logic [PIX_W-1:0]   v_pixel_q, v_pixel_d;
  logic               v_de_q, v_de_d;
  logic               v_hsync_q, v_hsync_d;
  logic               v_vsync_q, v_vsync_d;
  logic               align_err_q, align_err_d;
  logic [CNT_W-1:0]   h_active_q, h_active_d;
  logic [CNT_W-1:0]   v_active_q, v_active_d;
  logic               meas_valid_q, meas_valid_d;

  always_comb begin
    y8       = luma(bus.red, bus.green, bus.blue);
    y_now    = OUT_BPC'(y8 >> (8 - OUT_BPC));
    de_rise  = bus.de & ~last_de_q;
    de_fall  = ~bus.de & last_de_q;
    vs_rise  = bus.vsync & ~last_vs_q;
    skipping = (skip_q != 4'd0);
    last_de_d = bus.de;
    last_vs_d = bus.vsync;

    // A line start forces the pixel into slot 0; that completes a group only when PPC is 1.
    wr_slot = de_rise ? '0 : phase_q;
    emit    = (wr_slot == LAST);
    phase_d = emit ? '0 : wr_slot + 1'b1;

    slot_d = slot_q;
    for (int i = 0; i < PPC; i++) begin
      if (wr_slot == PW'(i)) slot_d[i] = y_now;
    end

    v_pclk_d  = emit;
    v_pixel_d = v_pixel_q;
    v_de_d    = v_de_q;
    v_hsync_d = v_hsync_q;
    v_vsync_d = v_vsync_q;
    if (emit) begin
      for (int i = 0; i < PPC; i++) begin
        v_pixel_d[(PPC-1-i)*OUT_BPC +: OUT_BPC] = slot_d[i];
      end
      v_de_d    = bus.de & ~skipping;
      v_hsync_d = bus.hsync & ~skipping;
      v_vsync_d = bus.vsync & ~skipping;
    end

    skip_d = (vs_rise && skipping) ? skip_q - 4'd1 : skip_q;

    // phase_q at the de fall is the number of pixels stranded in the unfinished group.
    if (de_fall && (phase_q != '0)) align_err_d = 1'b1;
    else if (bus.err_clr)           align_err_d = 1'b0;
    else                            align_err_d = align_err_q;

    hcnt_d     = hcnt_q;
    h_active_d = h_active_q;
    if (bus.de && (hcnt_q != CNT_MAX)) hcnt_d = hcnt_q + 1'b1;
    if (de_fall) begin
      h_active_d = hcnt_q;
      hcnt_d     = '0;
    end

    // The line ending in this cycle belongs to the frame a coincident vsync closes.
    vcnt_inc     = (de_fall && (vcnt_q != CNT_MAX)) ? vcnt_q + 1'b1 : vcnt_q;
    vcnt_d       = vcnt_inc;
    v_active_d   = v_active_q;
    meas_valid_d = meas_valid_q;
    if (vs_rise) begin
      v_active_d   = vcnt_inc;
      vcnt_d       = '0;
      meas_valid_d = 1'b1;
    end
  end

  always_ff @(posedge pclk or posedge rst_out) begin
    if (rst_out) begin
      phase_q      <= '0;
      slot_q       <= '{default: '0};
      last_de_q    <= 1'b0;
      last_vs_q    <= 1'b0;
      skip_q       <= SKIP_INIT;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      v_pclk_q     <= 1'b0;
      v_pixel_q    <= '0;
      v_de_q       <= 1'b0;
      v_hsync_q    <= 1'b0;
      v_vsync_q    <= 1'b0;
      align_err_q  <= 1'b0;
      h_active_q   <= '0;
      v_active_q   <= '0;
      meas_valid_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      slot_q       <= slot_d;
      last_de_q    <= last_de_d;
      last_vs_q    <= last_vs_d;
      skip_q       <= skip_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      v_pclk_q     <= v_pclk_d;
      v_pixel_q    <= v_pixel_d;
      v_de_q       <= v_de_d;
      v_hsync_q    <= v_hsync_d;
      v_vsync_q    <= v_vsync_d;
      align_err_q  <= align_err_d;
      h_active_q   <= h_active_d;
      v_active_q   <= v_active_d;
      meas_valid_q <= meas_valid_d;
    end
  end

  assign bus.v_pclk     = v_pclk_q;
  assign bus.v_pixel    = v_pixel_q;
  assign bus.v_de       = v_de_q;
  assign bus.v_hsync    = v_hsync_q;
  assign bus.v_vsync    = v_vsync_q;
  assign bus.align_err  = align_err_q;
  assign bus.h_active   = h_active_q;
  assign bus.v_active   = v_active_q;
  assign bus.meas_valid = meas_valid_q;
endmodule

// File: tb/tb_vin_pixel_packer.sv
// Bench for vin_pixel_packer: directed steps plus random frames, checked every cycle against a queue-based model.
module tb_vin_pixel_packer;
  localparam int PPC  = 2;
  localparam int BPC  = 8;
  localparam int SKIP = 3;
  localparam int CW   = 12;
  localparam int CMAX = (1 << CW) - 1;

  logic pclk = 1'b0;
  logic rst_out;
  int   total = 0;
  int   bad   = 0;
  int   npclk;
  int   nstrobe;
  int   wait_k;

  always #5 pclk = ~pclk;

  vin_pixel_packer_if #(.PPC(2), .OUT_BPC(8), .CNT_W(12)) b0 ();
  vin_pixel_packer_if #(.PPC(1), .OUT_BPC(8), .CNT_W(12)) b1 ();
  vin_pixel_packer_if #(.PPC(1), .OUT_BPC(6), .CNT_W(12)) b6 ();

  vin_pixel_packer #(.PPC(2), .OUT_BPC(8), .SKIP_FRAMES(3), .CNT_W(12)) dut (
    .pclk(pclk), .rst_out(rst_out), .bus(b0.slave));
  vin_pixel_packer #(.PPC(1), .OUT_BPC(8), .SKIP_FRAMES(0), .CNT_W(12)) dut_p1 (
    .pclk(pclk), .rst_out(rst_out), .bus(b1.slave));
  vin_pixel_packer #(.PPC(1), .OUT_BPC(6), .SKIP_FRAMES(0), .CNT_W(12)) dut_b6 (
    .pclk(pclk), .rst_out(rst_out), .bus(b6.slave));

  assign b1.de = b0.de;  assign b1.hsync = b0.hsync;  assign b1.vsync = b0.vsync;
  assign b1.red = b0.red; assign b1.green = b0.green; assign b1.blue = b0.blue;
  assign b1.err_clr = b0.err_clr;
  assign b6.de = b0.de;  assign b6.hsync = b0.hsync;  assign b6.vsync = b0.vsync;
  assign b6.red = b0.red; assign b6.green = b0.green; assign b6.blue = b0.blue;
  assign b6.err_clr = b0.err_clr;

  // Reference model: pixels of the open group, skip budget, line/frame counters, expected outputs.
  int   grp[$];
  int   skip_left, hcnt, vcnt;
  logic last_de, last_vs;
  logic e_pclk, e_de, e_hs, e_vs, e_err, e_mv;
  int   e_pix, e_h, e_v;

  task automatic mreset();
    grp.delete();
    skip_left = SKIP; hcnt = 0; vcnt = 0; last_de = 0; last_vs = 0;
    e_pclk = 0; e_de = 0; e_hs = 0; e_vs = 0; e_err = 0; e_mv = 0;
    e_pix = 0; e_h = 0; e_v = 0;
  endtask

  task automatic model(input logic de, input logic hs, input logic vs,
                       input int r, input int g, input int b, input logic clr);
    int   y;
    logic rise, fall, vrise, skipping;
    y        = ((77 * r + 150 * g + 29 * b) >> 8) >> (8 - BPC);
    rise     = de && !last_de;
    fall     = !de && last_de;
    vrise    = vs && !last_vs;
    skipping = (skip_left != 0);
    if (fall && grp.size() != 0) e_err = 1;
    else if (clr)                e_err = 0;
    if (rise) grp.delete();
    grp.push_back(y);
    e_pclk = 0;
    if (grp.size() == PPC) begin
      e_pclk = 1;
      e_pix  = 0;
      foreach (grp[i]) e_pix = (e_pix << BPC) | grp[i];
      e_de = de && !skipping;
      e_hs = hs && !skipping;
      e_vs = vs && !skipping;
      grp.delete();
    end
    if (fall) begin
      e_h  = hcnt;
      hcnt = 0;
      if (vcnt < CMAX) vcnt++;
    end else if (de && hcnt < CMAX) begin
      hcnt++;
    end
    if (vrise) begin
      e_v  = vcnt;
      vcnt = 0;
      e_mv = 1;
      if (skipping) skip_left--;
    end
    last_de = de;
    last_vs = vs;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".v_pclk"},     32'(b0.v_pclk),     32'(e_pclk));
    chk({tag, ".v_pixel"},    32'(b0.v_pixel),    32'(e_pix));
    chk({tag, ".v_de"},       32'(b0.v_de),       32'(e_de));
    chk({tag, ".v_hsync"},    32'(b0.v_hsync),    32'(e_hs));
    chk({tag, ".v_vsync"},    32'(b0.v_vsync),    32'(e_vs));
    chk({tag, ".align_err"},  32'(b0.align_err),  32'(e_err));
    chk({tag, ".h_active"},   32'(b0.h_active),   32'(e_h));
    chk({tag, ".v_active"},   32'(b0.v_active),   32'(e_v));
    chk({tag, ".meas_valid"}, 32'(b0.meas_valid), 32'(e_mv));
  endtask

  // Called at a falling edge: drive one pixel, advance the model, check after the rising edge.
  task automatic cyc(input logic de, input logic hs, input logic vs,
                     input int r, input int g, input int b, input logic clr);
    b0.de = de; b0.hsync = hs; b0.vsync = vs;
    b0.red = 8'(r); b0.green = 8'(g); b0.blue = 8'(b); b0.err_clr = clr;
    model(de, hs, vs, r, g, b, clr);
    @(posedge pclk);
    #1;
    check_all("cyc");
    if (b0.v_pclk) npclk++;
    if (b0.v_pclk && b0.v_de) nstrobe++;
    @(negedge pclk);
  endtask

  task automatic pix(input logic de, input int v);
    cyc(de, 1'b0, 1'b0, v, v, v, 1'b0);
  endtask

  task automatic rnd(input logic de, input logic hs, input logic vs, input logic clr);
    cyc(de, hs, vs, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), clr);
  endtask

  initial begin
    rst_out = 1'b1;
    b0.de = 0; b0.hsync = 0; b0.vsync = 0; b0.red = 0; b0.green = 0; b0.blue = 0; b0.err_clr = 0;
    mreset();
    repeat (3) @(negedge pclk);
    check_all("reset");
    chk("reset.p1_pixel", 32'(b1.v_pixel), 32'h0);
    rst_out = 1'b0;

    // Grey line of six pixels: three groups, each one cycle after its second pixel.
    repeat (3) pix(1'b0, 0);
    npclk = 0;
    for (int i = 1; i <= 6; i++) begin
      pix(1'b1, i * 16);
      if (i == 2) chk("t1.g0", 32'(b0.v_pixel), 32'h1020);
      if (i == 4) chk("t1.g1", 32'(b0.v_pixel), 32'h3040);
      if (i == 6) chk("t1.g2", 32'(b0.v_pixel), 32'h5060);
      if (i % 2 == 0) chk("t1.pclk", 32'(b0.v_pclk), 32'h1);
    end
    chk("t1.strobes", npclk, 3);
    repeat (3) pix(1'b0, 0);

    // Luma on the one-pixel-per-beat instances, de already high.
    pix(1'b1, 0);
    cyc(1, 0, 0, 255, 255, 255, 0);
    chk("t2.white", 32'(b1.v_pixel), 32'hFF);
    chk("t2.white6", 32'(b6.v_pixel), 32'h3F);
    chk("t2.pclk", 32'(b1.v_pclk), 32'h1);
    cyc(1, 0, 0, 255, 0, 0, 0);
    chk("t2.red", 32'(b1.v_pixel), 32'h4C);
    cyc(1, 0, 0, 0, 255, 0, 0);
    chk("t2.green", 32'(b1.v_pixel), 32'h95);
    cyc(1, 0, 0, 0, 0, 255, 0);
    chk("t2.blue", 32'(b1.v_pixel), 32'h1C);
    pix(1'b1, 0);
    repeat (3) pix(1'b0, 0);

    // Line start while a stale blank pixel sits in slot 0, then a 5-pixel line.
    wait_k = 0;
    pix(1'b0, 8'h77);
    while (!b0.v_pclk && wait_k < 4) begin
      pix(1'b0, 8'h77);
      wait_k++;
    end
    chk("t4.phase_sync", 32'(b0.v_pclk), 32'h1);
    pix(1'b0, 8'h99);
    npclk = 0;
    pix(1'b1, 8'h41);
    chk("t4.no_stale", 32'(b0.v_pclk), 32'h0);
    pix(1'b1, 8'h42);
    chk("t4.first", 32'(b0.v_pixel), 32'h4142);
    pix(1'b1, 8'h43); pix(1'b1, 8'h44); pix(1'b1, 8'h45);
    chk("t4.strobes", npclk, 2);
    pix(1'b0, 0);
    chk("t4.err_set", 32'(b0.align_err), 32'h1);
    chk("t4.h_active", 32'(b0.h_active), 32'd5);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("t4.err_clr", 32'(b0.align_err), 32'h0);

    // Reset mid-line, then packing restarts at slot 0 with de low.
    pix(1'b1, 8'h11); pix(1'b1, 8'h22); pix(1'b1, 8'h33);
    rst_out = 1'b1;
    #1;
    mreset();
    check_all("t6.rst");
    b0.de = 0;
    @(negedge pclk);
    rst_out = 1'b0;
    pix(1'b0, 8'hA0);
    pix(1'b0, 8'hB0);
    chk("t6.slot0", 32'(b0.v_pixel), 32'hA0B0);
    chk("t6.pclk", 32'(b0.v_pclk), 32'h1);

    // Five 20x10 frames, vsync at frame end: the first three are gated.
    for (int f = 0; f < 5; f++) begin
      nstrobe = 0;
      for (int l = 0; l < 10; l++) begin
        for (int p = 0; p < 20; p++) rnd(1'b1, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) rnd(1'b0, j < 2, 1'b0, 1'b0);
      end
      chk("t3.frame_beats", nstrobe, (f < 3) ? 0 : 100);
      rnd(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t5.h_active", 32'(b0.h_active), 32'd20);
      chk("t5.v_active", 32'(b0.v_active), 32'd10);
      chk("t5.meas_valid", 32'(b0.meas_valid), 32'h1);
      rnd(1'b0, 1'b0, 1'b1, 1'b0);
      rnd(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Random line lengths, blanking, err_clr and syncs against the model.
    for (int f = 0; f < 4; f++) begin
      int nl;
      nl = $urandom_range(3, 7);
      for (int l = 0; l < nl; l++) begin
        int len, blank;
        len   = $urandom_range(1, 9);
        blank = $urandom_range(1, 4);
        for (int p = 0; p < len; p++) rnd(1'b1, 1'b0, 1'b0, $urandom_range(0, 7) == 0);
        for (int j = 0; j < blank; j++) rnd(1'b0, $urandom_range(0, 1) == 1, 1'b0, $urandom_range(0, 7) == 0);
      end
      // Occasionally end the last line in the same cycle the vsync rises.
      if (f == 2) begin
        rnd(1'b1, 1'b0, 1'b0, 1'b0);
        rnd(1'b0, 1'b0, 1'b1, 1'b0);
      end else begin
        rnd(1'b0, 1'b0, 1'b1, 1'b0);
      end
      rnd(1'b0, 1'b0, 1'b1, 1'b0);
      rnd(1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
